// File: rtl/dmc_dma_responder_pkg.sv
// nes_apu: DMA responder state encoding, OAM DMA address defaults and CPU cycle parity codes
package nes_apu;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, DMC_RD, OAM_RD, OAM_WR} dma_state_t;
  localparam logic [15:0] OAM_PORT_DEF = 16'h2004;
  localparam logic [15:0] OAM_TRIGGER_DEF = 16'h4014;
  localparam logic PARITY_GET = 1'b0;
  localparam logic PARITY_PUT = 1'b1;
endpackage

// File: rtl/dmc_dma_responder_if.sv
// dmc_dma_responder_if: DMA-side memory bus; master drives mem_addr/mem_rd/mem_wr/mem_dout, slave returns mem_din
interface dmc_dma_responder_if;
  logic [15:0] mem_addr;
  logic mem_rd;
  logic mem_wr;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  modport master(output mem_addr, mem_rd, mem_wr, mem_dout, input mem_din);
  modport slave(input mem_addr, mem_rd, mem_wr, mem_dout, output mem_din);
endinterface

// File: rtl/dmc_dma_responder_oam_dma_seq.sv
// oam_dma_seq: OAM DMA pending flag, page/index counter and fetched-byte latch (trig/rd_done/wr_done in; pend/held/last/page/index/data out)
module oam_dma_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic       rd_done,
  input  logic       wr_done,
  input  logic [7:0] din,
  input  logic [7:0] mem_din,
  output logic       pend,
  output logic       held,
  output logic       last,
  output logic [7:0] page,
  output logic [7:0] index,
  output logic [7:0] data
);
  assign last = index == 8'hff;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= 1'b0;
      held <= 1'b0;
      page <= 8'h00;
      index <= 8'h00;
      data <= 8'h00;
    end else begin
      if (wr_done) begin
        index <= index + 8'd1;
        held <= 1'b0;
        if (last) pend <= 1'b0;
      end else if (trig && !pend) begin
        pend <= 1'b1;
        page <= din;
        index <= 8'h00;
      end
      if (rd_done) begin
        held <= 1'b1;
        data <= mem_din;
      end
    end
endmodule

// File: rtl/dmc_dma_responder.sv
// dmc_dma_responder: halts the CPU and steals bus cycles for DMC sample fetches (dmc_req/dmc_ack/dmc_data) and OAM DMA (write to OAM_TRIGGER), driving the mem bus
module dmc_dma_responder import nes_apu::*; #(
  parameter logic [15:0] OAM_PORT = OAM_PORT_DEF,
  parameter logic [15:0] OAM_TRIGGER = OAM_TRIGGER_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       odd_or_even,
  input  logic                       cpu_rnw,
  input  logic [15:0]                cpu_addr,
  input  logic [7:0]                 cpu_din,
  input  logic                       cpu_mw,
  input  logic                       dmc_req,
  input  logic [15:0]                dmc_addr,
  output logic                       dmc_ack,
  output logic [7:0]                 dmc_data,
  output logic                       cpu_pause,
  output logic                       dma_busy,
  dmc_dma_responder_if.master        mem
);
  dma_state_t state;
  dma_state_t go;
  logic pend;
  logic held;
  logic last;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] oam_byte;
  oam_dma_seq u_seq (
    .clk(clk),
    .reset(reset),
    .trig(ce && cpu_mw && cpu_addr == OAM_TRIGGER),
    .rd_done(ce && state == OAM_RD),
    .wr_done(ce && state == OAM_WR),
    .din(cpu_din),
    .mem_din(mem.mem_din),
    .pend(pend),
    .held(held),
    .last(last),
    .page(page),
    .index(index),
    .data(oam_byte)
  );
  // Reads must land on get cycles, so leave HALT/ALIGN only from a put cycle; a dropped request aborts to IDLE
  assign go = !(dmc_req || pend) ? IDLE : odd_or_even != PARITY_PUT ? ALIGN : dmc_req ? DMC_RD : OAM_RD;
  assign cpu_pause = state != IDLE;
  assign dma_busy = state != IDLE;
  assign mem.mem_rd = state == DMC_RD || state == OAM_RD;
  assign mem.mem_wr = state == OAM_WR;
  assign mem.mem_dout = state == OAM_WR ? oam_byte : 8'h00;
  assign mem.mem_addr = state == DMC_RD ? dmc_addr : state == OAM_RD ? {page, index} : state == OAM_WR ? OAM_PORT : 16'h0000;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      dmc_ack <= 1'b0;
      dmc_data <= 8'h00;
    end else if (ce) begin
      dmc_ack <= state == DMC_RD;
      if (state == DMC_RD) dmc_data <= mem.mem_din;
      case (state)
        IDLE:    if (dmc_req || pend) state <= HALT;
        HALT:    if (cpu_rnw || go == IDLE) state <= go;
        ALIGN:   state <= go;
        DMC_RD:  state <= held ? OAM_WR : pend ? ALIGN : IDLE;
        OAM_RD:  state <= OAM_WR;
        OAM_WR:  state <= last ? (dmc_req ? ALIGN : IDLE) : dmc_req ? DMC_RD : OAM_RD;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/dmc_dma_responder.md
DMC_DMA_RESPONDER -- requirements
Module: dmc_dma_responder

Interface
REQ-001 SHALL have parameter OAM_PORT, default 16'h2004, meaning PPU OAM data write address.
REQ-002 SHALL have parameter OAM_TRIGGER, default 16'h4014, meaning CPU register that starts OAM DMA.
REQ-003 clk  in  1  sole clock; all flops on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ce  in  1  CPU-cycle clock enable; state advances only when ce=1.
REQ-006 odd_or_even  in  1  CPU cycle parity; 0=get (read) cycle, 1=put (write) cycle.
REQ-007 cpu_rnw  in  1  current CPU bus cycle is a read.
REQ-008 cpu_addr  in  16 / cpu_din  in  8 / cpu_mw  in  1  CPU address, write data, write strobe.
REQ-009 dmc_req  in  1 / dmc_addr  in  16  DMC sample-fetch request level and address.
REQ-010 dmc_ack  out  1 / dmc_data  out  8  one-ce-cycle fetch-complete pulse and fetched byte.
REQ-011 mem_addr  out  16 / mem_rd  out  1 / mem_wr  out  1 / mem_dout  out  8 / mem_din  in  8  DMA-side bus.
REQ-012 cpu_pause  out  1 / dma_busy  out  1  CPU halt (RDY low) and DMA-in-progress flag.

Function
REQ-013 States SHALL be IDLE, HALT, ALIGN, DMC_RD, OAM_RD, OAM_WR; transitions only on ce=1.
REQ-014 A ce cycle with cpu_mw=1 and cpu_addr=OAM_TRIGGER SHALL latch page=cpu_din, index=0, oam_pend=1; such writes SHALL be ignored while oam_pend=1.
REQ-015 IDLE -> HALT when dmc_req=1 or oam_pend=1; cpu_pause and dma_busy SHALL be 1 in every state except IDLE.
REQ-016 HALT SHALL persist until a ce cycle with cpu_rnw=1, then -> ALIGN (CPU write cycles are never stolen).
REQ-017 ALIGN -> DMC_RD on a get cycle if dmc_req=1, else -> OAM_RD on a get cycle if oam_pend=1; on a put cycle ALIGN stays (alignment wait, one cycle).
REQ-018 DMC_RD: mem_addr=dmc_addr, mem_rd=1 for exactly that ce cycle; mem_din captured into dmc_data at its end; dmc_ack=1 for the following ce cycle only.
REQ-019 After DMC_RD: -> OAM_WR if an OAM byte is held unwritten, else ALIGN if oam_pend=1, else IDLE.
REQ-020 OAM_RD (get cycle): mem_addr={page,index}, mem_rd=1, byte latched -> OAM_WR.
REQ-021 OAM_WR (put cycle): mem_addr=OAM_PORT, mem_wr=1, mem_dout=latched byte; index increments 8-bit.
REQ-022 After OAM_WR: if index wrapped 255->0, clear oam_pend and -> IDLE (or ALIGN if dmc_req=1); else -> OAM_RD, unless dmc_req=1, then -> DMC_RD (DMC takes the next get cycle, OAM resumes at same index).
REQ-023 Simultaneous dmc_req rise and OAM_TRIGGER write in IDLE: DMC SHALL be serviced first.
REQ-024 dmc_req dropping before DMC_RD SHALL cancel the fetch (no ack); mem_rd and mem_wr SHALL never both be 1.
REQ-025 Full OAM DMA with no DMC interference SHALL take 513 or 514 ce cycles of cpu_pause (1 halt + 0/1 align + 512).

Reset
REQ-026 reset=0 SHALL immediately force IDLE, oam_pend=0, page=0, index=0, dmc_data=0, and all outputs 0 (mem_addr=0), aborting any transfer mid-operation.
REQ-027 Pending requests SHALL be lost on reset; dmc_req still high after release restarts from IDLE.

Structure
REQ-028 State enum, OAM_PORT/OAM_TRIGGER defaults and parity encoding SHALL live in the shared nes_apu package.
REQ-029 Single module; one optional sub-module oam_dma_seq (page/index counter and byte latch).

Verification
REQ-030 dmc_req=1, dmc_addr=16'hC123, mem_din=8'h5A, CPU reading -> cpu_pause within 1 ce, mem_rd at C123 on a get cycle, dmc_ack pulse with dmc_data=8'h5A, 3-4 ce total.
REQ-031 Write 8'h02 to 16'h4014 -> 256 reads 0200..02FF each followed by mem_wr to 2004 with same byte; pause 513/514 ce; index returns 0.
REQ-032 dmc_req=1 during OAM at index 8'h40 -> one DMC_RD inserted, next OAM_RD at 0240, no byte skipped or duplicated.
REQ-033 HALT with cpu_rnw=0 for 3 ce -> no mem access until cpu_rnw=1.
REQ-034 reset=0 asserted mid-OAM at index 8'h80 -> all outputs 0 same cycle; after release with no request, stays IDLE.
REQ-035 Second write to 4014 during OAM -> ignored; transfer completes from original page.
